// File: rtl/usb_data_buffer.sv
// -----------------------------------------------------------------------------
// usb_data_buffer
//
// 64-byte circular buffer shared by the USB RX/TX byte paths and the AHB slave
// word path. One storage array, one write pointer, one read pointer and one
// occupancy count serve both sides. The downstream buffer-reservation FSM
// watches bufferOccupancy to detect "TX packet loaded" / "RX packet drained".
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   clear              - synchronous flush of pointers/occupancy/read data
//   rxByteValid/rxByte - USB RX byte store (wins write arbitration)
//   txByteRead/txByte  - USB TX byte pop (wins read arbitration), popped byte
//   ahbWrEn/Data/Size  - AHB 1/2/4-byte little-endian store
//   ahbRdEn/Size/Data  - AHB 1/2/4-byte pop, popped word (upper bytes zero)
//   bufferOccupancy    - bytes held; empty/full decoded from it
//   overflow/underflow - one-cycle pulse: write/read dropped
//   collision          - one-cycle pulse: AHB request lost same-side arbitration
//
// Request semantics: every request input is a single-cycle strobe sampled on
// the rising edge. There is no ready/backpressure; a request that cannot be
// honoured is dropped and reported by a registered pulse on the next cycle.
// -----------------------------------------------------------------------------
module usb_data_buffer #(
    parameter int DEPTH = 64,
    parameter int OCC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             rxByteValid,
    input  logic [7:0]       rxByte,
    input  logic             txByteRead,
    output logic [7:0]       txByte,
    input  logic             ahbWrEn,
    input  logic [31:0]      ahbWrData,
    input  logic [1:0]       ahbWrSize,
    input  logic             ahbRdEn,
    input  logic [1:0]       ahbRdSize,
    output logic [31:0]      ahbRdData,
    output logic [OCC_W-1:0] bufferOccupancy,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             collision
);

    localparam int PTR_W = $clog2(DEPTH);

    // Size encoding: 0 -> 1 byte, 1 -> 2 bytes, 2 -> 4 bytes, 3 -> 0 (illegal).
    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Storage (never reset or cleared; only pointers define valid content)
    logic [7:0] mem [DEPTH];

    // Registered state
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [31:0]      ahb_rd_data_q, ahb_rd_data_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             collision_q, collision_d;

    // Write-side decode
    logic             wr_req;
    logic             wr_from_rx;
    logic             col_wr;
    logic [2:0]       wr_n;
    logic [OCC_W:0]   wr_sum;
    logic             wr_ok;
    logic [7:0]       wr_byte [4];

    // Read-side decode
    logic             rd_req;
    logic             rd_to_tx;
    logic             col_rd;
    logic [2:0]       rd_n;
    logic             rd_ok;
    logic [7:0]       rd_byte [4];
    logic [31:0]      rd_word;

    // -------------------------------------------------------------------------
    // Write arbitration and acceptance
    // -------------------------------------------------------------------------
    always_comb begin
        wr_req     = rxByteValid | ahbWrEn;
        wr_from_rx = 1'b0;
        col_wr     = 1'b0;
        wr_n       = 3'd0;
        if (rxByteValid) begin
            wr_from_rx = 1'b1;
            wr_n       = 3'd1;
            col_wr     = ahbWrEn;
        end else if (ahbWrEn) begin
            wr_n       = size_to_bytes(ahbWrSize);
        end
        // One extra bit so occ + 4 cannot wrap before the DEPTH compare.
        wr_sum = {1'b0, occ_q} + {{(OCC_W-2){1'b0}}, wr_n};
        // wr_n == 0 only for the illegal size code: dropped as an overflow.
        wr_ok  = wr_req && (wr_n != 3'd0) && (wr_sum <= (OCC_W+1)'(DEPTH));

        wr_byte[0] = wr_from_rx ? rxByte : ahbWrData[7:0];
        wr_byte[1] = ahbWrData[15:8];
        wr_byte[2] = ahbWrData[23:16];
        wr_byte[3] = ahbWrData[31:24];
    end

    // -------------------------------------------------------------------------
    // Read arbitration and acceptance (against start-of-cycle occupancy, so a
    // same-cycle write never feeds a read)
    // -------------------------------------------------------------------------
    always_comb begin
        rd_req   = txByteRead | ahbRdEn;
        rd_to_tx = 1'b0;
        col_rd   = 1'b0;
        rd_n     = 3'd0;
        if (txByteRead) begin
            rd_to_tx = 1'b1;
            rd_n     = 3'd1;
            col_rd   = ahbRdEn;
        end else if (ahbRdEn) begin
            rd_n     = size_to_bytes(ahbRdSize);
        end
        rd_ok = rd_req && (rd_n != 3'd0) && (occ_q >= {{(OCC_W-3){1'b0}}, rd_n});

        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            // Pointer arithmetic is PTR_W wide so accesses wrap around the ring.
            rd_byte[k] = mem[rp_q + PTR_W'(k)];
            if (3'(k) < rd_n) begin
                rd_word[8*k +: 8] = rd_byte[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wp_d          = wp_q;
        rp_d          = rp_q;
        occ_d         = occ_q;
        tx_byte_d     = tx_byte_q;
        ahb_rd_data_d = ahb_rd_data_q;
        overflow_d    = 1'b0;
        underflow_d   = 1'b0;
        collision_d   = 1'b0;

        if (clear) begin
            // Flush wins over everything; dropped requests raise no pulses.
            wp_d          = '0;
            rp_d          = '0;
            occ_d         = '0;
            tx_byte_d     = '0;
            ahb_rd_data_d = '0;
        end else begin
            if (wr_ok) begin
                wp_d = wp_q + PTR_W'(wr_n);
            end
            if (rd_ok) begin
                rp_d = rp_q + PTR_W'(rd_n);
                if (rd_to_tx) begin
                    tx_byte_d = rd_byte[0];
                end else begin
                    ahb_rd_data_d = rd_word;
                end
            end
            occ_d = occ_q + (wr_ok ? OCC_W'(wr_n) : '0) - (rd_ok ? OCC_W'(rd_n) : '0);
            // Only the winning request can overflow/underflow; the losing AHB
            // request is reported through collision alone.
            overflow_d  = wr_req && !wr_ok;
            underflow_d = rd_req && !rd_ok;
            collision_d = col_wr | col_rd;
        end
    end

    // -------------------------------------------------------------------------
    // Storage write
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < wr_n) begin
                    mem[wp_q + PTR_W'(k)] <= wr_byte[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q          <= '0;
            rp_q          <= '0;
            occ_q         <= '0;
            tx_byte_q     <= '0;
            ahb_rd_data_q <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            occ_q         <= occ_d;
            tx_byte_q     <= tx_byte_d;
            ahb_rd_data_q <= ahb_rd_data_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            collision_q   <= collision_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign txByte          = tx_byte_q;
    assign ahbRdData       = ahb_rd_data_q;
    assign bufferOccupancy = occ_q;
    assign empty           = (occ_q == '0);
    assign full            = (occ_q == OCC_W'(DEPTH));
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign collision       = collision_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
module tb_usb_data_buffer;

    localparam int DEPTH = 64;
    localparam int OCC_W = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             clear;
    logic             rxByteValid;
    logic [7:0]       rxByte;
    logic             txByteRead;
    logic [7:0]       txByte;
    logic             ahbWrEn;
    logic [31:0]      ahbWrData;
    logic [1:0]       ahbWrSize;
    logic             ahbRdEn;
    logic [1:0]       ahbRdSize;
    logic [31:0]      ahbRdData;
    logic [OCC_W-1:0] bufferOccupancy;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             collision;

    usb_data_buffer #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .rxByteValid     (rxByteValid),
        .rxByte          (rxByte),
        .txByteRead      (txByteRead),
        .txByte          (txByte),
        .ahbWrEn         (ahbWrEn),
        .ahbWrData       (ahbWrData),
        .ahbWrSize       (ahbWrSize),
        .ahbRdEn         (ahbRdEn),
        .ahbRdSize       (ahbRdSize),
        .ahbRdData       (ahbRdData),
        .bufferOccupancy (bufferOccupancy),
        .empty           (empty),
        .full            (full),
        .overflow        (overflow),
        .underflow       (underflow),
        .collision       (collision)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Expected per-edge response: {occ[6:0], txByte[7:0], ahbRdData[31:0], ovf, unf, col}
    logic [49:0] exp_q[$];
    logic [49:0] mon_e;

    // Reference model: buffer contents as a plain byte FIFO
    logic [7:0]  mdl_q[$];
    logic [7:0]  m_tx;
    logic [31:0] m_ahb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_occ"},   64'(bufferOccupancy), 64'd0);
        chk({tag, "_empty"}, 64'(empty),           64'd1);
        chk({tag, "_full"},  64'(full),            64'd0);
        chk({tag, "_tx"},    64'(txByte),          64'd0);
        chk({tag, "_ahb"},   64'(ahbRdData),       64'd0);
        chk({tag, "_ovf"},   64'(overflow),        64'd0);
        chk({tag, "_unf"},   64'(underflow),       64'd0);
        chk({tag, "_col"},   64'(collision),       64'd0);
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of requests and pushes the model's expected response.
    task automatic drive(input logic rxv, input logic [7:0] rxb, input logic txr,
                         input logic we, input logic [31:0] wd, input logic [1:0] ws,
                         input logic re, input logic [1:0] rs, input logic clr);
        int occ0, nw, nr;
        logic ovf, unf, col;
        logic [7:0] wb [4];
        @(negedge clk);
        #1;
        rxByteValid = rxv; rxByte = rxb; txByteRead = txr;
        ahbWrEn = we; ahbWrData = wd; ahbWrSize = ws;
        ahbRdEn = re; ahbRdSize = rs; clear = clr;
        ovf = 1'b0; unf = 1'b0; col = 1'b0;
        for (int k = 0; k < 4; k++) wb[k] = wd[8*k +: 8];
        if (clr) begin
            mdl_q.delete();
            m_tx  = '0;
            m_ahb = '0;
        end else begin
            occ0 = mdl_q.size();
            nr = 0;
            if (txr) begin
                nr  = 1;
                col = re;
            end else if (re) begin
                nr = nbytes(rs);
            end
            nw = 0;
            if (rxv) begin
                nw    = 1;
                col   = col | we;
                wb[0] = rxb;
            end else if (we) begin
                nw = nbytes(ws);
            end
            if ((txr || re) && (nr == 0 || occ0 < nr)) begin
                unf = 1'b1;
                nr  = 0;
            end
            if ((rxv || we) && (nw == 0 || occ0 + nw > DEPTH)) begin
                ovf = 1'b1;
                nw  = 0;
            end
            if (nr > 0) begin
                if (txr) begin
                    m_tx = mdl_q.pop_front();
                end else begin
                    m_ahb = '0;
                    for (int k = 0; k < nr; k++) m_ahb[8*k +: 8] = mdl_q.pop_front();
                end
            end
            for (int k = 0; k < nw; k++) mdl_q.push_back(wb[k]);
        end
        exp_q.push_back({7'(mdl_q.size()), m_tx, m_ahb, ovf, unf, col});
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rx(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic ahb_wr(input logic [31:0] d, input logic [1:0] s);
        drive(1'b0, 8'h00, 1'b0, 1'b1, d, s, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic ahb_rd(input logic [1:0] s);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, s, 1'b0);
    endtask

    task automatic do_clear();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
    endtask

    // Sample right after the edge that consumed the last driven cycle.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("occupancy", 64'(bufferOccupancy), 64'(mon_e[49:43]));
            chk("txByte",    64'(txByte),          64'(mon_e[42:35]));
            chk("ahbRdData", 64'(ahbRdData),       64'(mon_e[34:3]));
            chk("overflow",  64'(overflow),        64'(mon_e[2]));
            chk("underflow", 64'(underflow),       64'(mon_e[1]));
            chk("collision", 64'(collision),       64'(mon_e[0]));
            chk("empty",     64'(empty),           64'(mon_e[49:43] == 7'd0));
            chk("full",      64'(full),            64'(mon_e[49:43] == 7'd64));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pw, pr;
        logic rxv, txr, we, re, clr;
        logic [1:0] ws, rs;

        rst = 1'b1; clear = 1'b0; rxByteValid = 1'b0; rxByte = '0; txByteRead = 1'b0;
        ahbWrEn = 1'b0; ahbWrData = '0; ahbWrSize = '0; ahbRdEn = 1'b0; ahbRdSize = '0;
        m_tx = '0; m_ahb = '0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: AHB 2-byte write then TX pop
        ahb_wr(32'h4433_2211, 2'd1);
        after_edge();
        chk("tp1_occ", 64'(bufferOccupancy), 64'd2);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("tp1_tx", 64'(txByte), 64'h11);
        chk("tp1_occ2", 64'(bufferOccupancy), 64'd1);
        do_clear();

        // 2: fill with 64 RX bytes, then overflow
        for (int i = 0; i < 64; i++) rx(8'(i));
        after_edge();
        chk("tp2_full", 64'(full), 64'd1);
        chk("tp2_occ", 64'(bufferOccupancy), 64'd64);
        rx(8'hEE);
        after_edge();
        chk("tp2_ovf", 64'(overflow), 64'd1);
        chk("tp2_occ_hold", 64'(bufferOccupancy), 64'd64);

        // 3: occupancy 62, 4-byte write dropped, 2-byte accepted
        ahb_rd(2'd1);
        after_edge();
        chk("tp3_rd", 64'(ahbRdData), 64'h0000_0100);
        ahb_wr(32'h1234_5678, 2'd2);
        after_edge();
        chk("tp3_ovf", 64'(overflow), 64'd1);
        chk("tp3_occ62", 64'(bufferOccupancy), 64'd62);
        ahb_wr(32'h0000_BEEF, 2'd1);
        after_edge();
        chk("tp3_occ64", 64'(bufferOccupancy), 64'd64);

        // 4: pointers to 62, 4-byte wrap access
        do_clear();
        for (int i = 0; i < 31; i++) begin
            ahb_wr($urandom, 2'd1);
            ahb_rd(2'd1);
        end
        ahb_wr(32'hA3A2_A1A0, 2'd2);
        ahb_rd(2'd2);
        after_edge();
        chk("tp4_data", 64'(ahbRdData), 64'hA3A2_A1A0);
        chk("tp4_empty", 64'(empty), 64'd1);
        ahb_wr(32'hC3C2_C1C0, 2'd2);
        ahb_rd(2'd2);
        after_edge();
        chk("tp4_data2", 64'(ahbRdData), 64'hC3C2_C1C0);

        // 5: both sides collide at occupancy 3
        rx(8'h31); rx(8'h32); rx(8'h33);
        drive(1'b1, 8'h5A, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b1, 2'd0, 1'b0);
        after_edge();
        chk("tp5_col", 64'(collision), 64'd1);
        chk("tp5_tx", 64'(txByte), 64'h31);
        chk("tp5_occ", 64'(bufferOccupancy), 64'd3);

        // Read of empty buffer in same cycle as write underflows
        do_clear();
        drive(1'b1, 8'h77, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("bypass_unf", 64'(underflow), 64'd1);

        // Illegal size codes
        ahb_wr(32'h0, 2'd3);
        ahb_rd(2'd3);

        // 6: clear with simultaneous write, then reset mid-fill
        for (int i = 0; i < 9; i++) rx(8'(8'h80 + i));
        drive(1'b1, 8'h99, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        after_edge();
        chk("tp6_occ", 64'(bufferOccupancy), 64'd0);
        chk("tp6_tx", 64'(txByte), 64'd0);
        chk("tp6_pulses", 64'({overflow, underflow, collision}), 64'd0);
        for (int i = 0; i < 5; i++) rx(8'(i));
        ahb_rd(2'd0);
        after_edge();
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        mdl_q.delete();
        m_tx = '0;
        m_ahb = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        rxByteValid = 1'b0; ahbRdEn = 1'b0;

        // Random phase: alternate fill-heavy and drain-heavy segments
        for (int seg = 0; seg < 6; seg++) begin
            pw = (seg % 2 == 0) ? 70 : 20;
            pr = (seg % 2 == 0) ? 20 : 70;
            for (int c = 0; c < 120; c++) begin
                rxv = ($urandom_range(0, 99) < pw / 2);
                we  = ($urandom_range(0, 99) < pw);
                txr = ($urandom_range(0, 99) < pr / 2);
                re  = ($urandom_range(0, 99) < pr);
                clr = ($urandom_range(0, 199) == 0);
                ws  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                rs  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                drive(rxv, 8'($urandom), txr, we, $urandom, ws, re, rs, clr);
            end
        end
        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
